// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM encodings, default response bytes
// and the command-byte field helper.
package uart_cmd_ctrl_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DATA    = 3'd1;
    localparam logic [2:0] ST_BUS     = 3'd2;
    localparam logic [2:0] ST_RD      = 3'd3;
    localparam logic [2:0] ST_TX_REQ  = 3'd4;
    localparam logic [2:0] ST_TX_WAIT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_DATA    = ST_DATA,
        S_BUS     = ST_BUS,
        S_RD      = ST_RD,
        S_TX_REQ  = ST_TX_REQ,
        S_TX_WAIT = ST_TX_WAIT
    } state_t;

    localparam logic [7:0] ACK_DEF = 8'hA5;
    localparam logic [7:0] NAK_DEF = 8'h5A;

    // The RW flag is the command MSB; the reserved field sits between it and the address.
    function automatic int cmd_rw_bit(input int bitwidth);
        return bitwidth - 32'sd1;
    endfunction

    function automatic logic cmd_rsv_is_zero(input logic [31:0] cmd, input int rsv_msb,
                                             input int rsv_lsb);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i >= rsv_lsb) && (i <= rsv_msb) && cmd[i]) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Loadable saturating cycle counter; o_done flags that TIMEOUT-1 has been reached.
module uart_cmd_timeout
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1000000
) (
    input  logic CLK_SYS,
    input  logic RSTN,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Count while enabled, hold at the limit so o_done stays asserted
    always_ff @(posedge CLK_SYS) begin
        if (!RSTN) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_done = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-side controller: turns 1-2 byte UART frames into register bus accesses and
// returns one response byte through the PHY.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int                     BITWIDTH   = 8,
    parameter int                     ADDR_WIDTH = 4,
    parameter int                     TIMEOUT    = 1000000,
    parameter logic [BITWIDTH-1:0]    ACK        = BITWIDTH'(ACK_DEF),
    parameter logic [BITWIDTH-1:0]    NAK        = BITWIDTH'(NAK_DEF)
) (
    input  logic                  CLK_SYS,
    input  logic                  RSTN,
    input  logic                  UART_RDY,
    input  logic [BITWIDTH-1:0]   UART_DOUT,
    output logic                  UART_START_FLAG,
    output logic [BITWIDTH-1:0]   UART_DIN,
    output logic [ADDR_WIDTH-1:0] REG_ADDR,
    output logic [BITWIDTH-1:0]   REG_WDATA,
    output logic                  REG_WE,
    output logic                  REG_RE,
    input  logic [BITWIDTH-1:0]   REG_RDATA,
    output logic                  ERR_TIMEOUT,
    output logic                  BUSY
);

    localparam int RW_BIT = cmd_rw_bit(BITWIDTH);

    state_t                r_state;
    logic                  r_rdy_q;
    logic                  r_own_tx;
    logic                  r_is_wr;
    logic [BITWIDTH-1:0]   r_tx_byte;
    logic                  r_start;
    logic [BITWIDTH-1:0]   r_din;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BITWIDTH-1:0]   r_wdata;
    logic                  r_we;
    logic                  r_re;
    logic                  r_err;

    logic w_rdy_rise;
    logic w_rx_evt;
    logic w_cmd_wr;
    logic w_cmd_ok;
    logic w_tmo_done;

    assign w_rdy_rise = UART_RDY & ~r_rdy_q;
    // The frame ending our own transmit is the PHY echo, not a command
    assign w_rx_evt   = w_rdy_rise & ~r_own_tx;
    assign w_cmd_wr   = UART_DOUT[RW_BIT];
    assign w_cmd_ok   = cmd_rsv_is_zero(32'(UART_DOUT), BITWIDTH - 2, ADDR_WIDTH);

    uart_cmd_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK_SYS (CLK_SYS),
        .RSTN    (RSTN),
        .i_clr   (r_state != S_DATA),
        .i_en    (r_state == S_DATA),
        .o_done  (w_tmo_done)
    );

    // Frame FSM with RDY edge tracking and registered bus/PHY outputs
    always_ff @(posedge CLK_SYS) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_rdy_q   <= 1'b0;
            r_own_tx  <= 1'b0;
            r_is_wr   <= 1'b0;
            r_tx_byte <= '0;
            r_start   <= 1'b0;
            r_din     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_re      <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rdy_q <= UART_RDY;
            r_start <= 1'b0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_err   <= 1'b0;
            if (w_rdy_rise) begin
                r_own_tx <= 1'b0;
            end else begin
                r_own_tx <= r_own_tx;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_rx_evt && !w_cmd_ok) begin
                        r_tx_byte <= NAK;
                        r_state   <= S_TX_REQ;
                    end else if (w_rx_evt) begin
                        r_addr  <= UART_DOUT[ADDR_WIDTH-1:0];
                        r_is_wr <= w_cmd_wr;
                        r_state <= w_cmd_wr ? S_DATA : S_BUS;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (w_rx_evt) begin
                        r_wdata <= UART_DOUT;
                        r_state <= S_BUS;
                    end else if (w_tmo_done) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_BUS: begin
                    if (r_is_wr) begin
                        r_we      <= 1'b1;
                        r_tx_byte <= ACK;
                        r_state   <= S_TX_REQ;
                    end else begin
                        r_re    <= 1'b1;
                        r_state <= S_RD;
                    end
                end
                S_RD: begin
                    r_tx_byte <= REG_RDATA;
                    r_state   <= S_TX_REQ;
                end
                S_TX_REQ: begin
                    if (UART_RDY) begin
                        r_din    <= r_tx_byte;
                        r_start  <= 1'b1;
                        r_own_tx <= 1'b1;
                        r_state  <= S_TX_WAIT;
                    end else begin
                        r_state <= S_TX_REQ;
                    end
                end
                S_TX_WAIT: begin
                    if (w_rdy_rise) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_TX_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign UART_START_FLAG = r_start;
    assign UART_DIN        = r_din;
    assign REG_ADDR        = r_addr;
    assign REG_WDATA       = r_wdata;
    assign REG_WE          = r_we;
    assign REG_RE          = r_re;
    assign ERR_TIMEOUT     = r_err;
    assign BUSY            = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed + randomized bench for uart_cmd_ctrl against a transaction-level register model.
module tb_uart_cmd_ctrl;

    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] dout = 8'h00;
    logic       start_flag;
    logic [7:0] din;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       err_tmo;
    logic       busy;

    logic [7:0] phy_mem [16] = '{default: 8'h00};
    logic [7:0] ref_mem [16] = '{default: 8'h00};

    int n_cmp = 0;
    int n_mis = 0;
    int we_cnt = 0;
    int re_cnt = 0;

    uart_cmd_ctrl #(
        .BITWIDTH   (8),
        .ADDR_WIDTH (4),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK_SYS         (clk),
        .RSTN            (rstn),
        .UART_RDY        (rdy),
        .UART_DOUT       (dout),
        .UART_START_FLAG (start_flag),
        .UART_DIN        (din),
        .REG_ADDR        (reg_addr),
        .REG_WDATA       (reg_wdata),
        .REG_WE          (reg_we),
        .REG_RE          (reg_re),
        .REG_RDATA       (reg_rdata),
        .ERR_TIMEOUT     (err_tmo),
        .BUSY            (busy)
    );

    always #5 clk = ~clk;

    assign reg_rdata = phy_mem[reg_addr];

    always @(posedge clk) begin
        if (reg_we) begin
            phy_mem[reg_addr] <= reg_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (reg_re) begin
            re_cnt <= re_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start"}, 32'(start_flag), 32'd0);
        chk({tag, "_din"},   32'(din),        32'd0);
        chk({tag, "_addr"},  32'(reg_addr),   32'd0);
        chk({tag, "_wdata"}, 32'(reg_wdata),  32'd0);
        chk({tag, "_we"},    32'(reg_we),     32'd0);
        chk({tag, "_re"},    32'(reg_re),     32'd0);
        chk({tag, "_err"},   32'(err_tmo),    32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
    endtask

    // PHY delivers a byte: RDY low for a while, then rises with DOUT valid
    task automatic send_byte(input logic [7:0] b);
        rdy = 1'b0;
        repeat (3) tick();
        dout = b;
        rdy  = 1'b1;
        tick();
    endtask

    // PHY transmits the response; its closing RDY edge carries an echo byte that looks like a write
    task automatic finish_tx(input string tag);
        tick();
        rdy = 1'b0;
        repeat (4) tick();
        dout = 8'h83;
        rdy  = 1'b1;
        tick();
        chk({tag, "_idle_after_tx"}, 32'(busy), 32'd0);
        repeat (3) tick();
        chk({tag, "_echo_ignored"}, 32'(busy), 32'd0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        int we0, re0;
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte({4'b1000, a});
        chk("wr_busy", 32'(busy), 32'd1);
        send_byte(d);
        tick();
        chk("wr_we", 32'(reg_we), 32'd1);
        chk("wr_addr", 32'(reg_addr), 32'(a));
        chk("wr_wdata", 32'(reg_wdata), 32'(d));
        ref_mem[a] = d;
        tick();
        chk("wr_start", 32'(start_flag), 32'd1);
        chk("wr_din", 32'(din), 32'hA5);
        finish_tx("wr");
        chk("wr_we_count", 32'(we_cnt - we0), 32'd1);
        chk("wr_re_count", 32'(re_cnt - re0), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] a);
        int we0, re0;
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte({4'b0000, a});
        tick();
        chk("rd_re", 32'(reg_re), 32'd1);
        chk("rd_addr", 32'(reg_addr), 32'(a));
        repeat (2) tick();
        chk("rd_start", 32'(start_flag), 32'd1);
        chk("rd_din", 32'(din), 32'(ref_mem[a]));
        finish_tx("rd");
        chk("rd_we_count", 32'(we_cnt - we0), 32'd0);
        chk("rd_re_count", 32'(re_cnt - re0), 32'd1);
    endtask

    task automatic do_invalid(input logic [7:0] cmd);
        int we0, re0;
        we0 = we_cnt;
        re0 = re_cnt;
        send_byte(cmd);
        tick();
        chk("inv_start", 32'(start_flag), 32'd1);
        chk("inv_din", 32'(din), 32'h5A);
        finish_tx("inv");
        chk("inv_we_count", 32'(we_cnt - we0), 32'd0);
        chk("inv_re_count", 32'(re_cnt - re0), 32'd0);
    endtask

    initial begin
        logic [3:0] a;
        logic [7:0] d;
        int         kind;
        int         n;
        int         we0;

        repeat (3) tick();
        rstn = 1'b1;
        tick();
        check_zero("reset");

        do_write(4'd3, 8'h3C);
        do_write(4'd5, 8'h77);
        do_read(4'd5);
        do_invalid(8'h40);

        // Write command with no data byte must time out after TMO cycles
        we0 = we_cnt;
        send_byte(8'h81);
        n = 0;
        while ((err_tmo !== 1'b1) && (n < 2 * TMO)) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        tick();
        chk("tmo_pulse_len", 32'(err_tmo), 32'd0);
        chk("tmo_idle", 32'(busy), 32'd0);
        chk("tmo_no_we", 32'(we_cnt - we0), 32'd0);
        do_read(4'd2);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            a    = 4'($urandom_range(0, 15));
            d    = 8'($urandom);
            case (kind)
                0:       do_write(a, d);
                1:       do_read(a);
                default: do_invalid({1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), a});
            endcase
        end

        // Reset while waiting for the PHY to finish the response frame
        send_byte(8'h87);
        send_byte(8'h99);
        tick();
        ref_mem[7] = 8'h99;
        repeat (2) tick();
        rdy = 1'b0;
        tick();
        chk("txwait_busy", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_zero("rst_txwait");
        tick();
        chk("rst_txwait_idle", 32'(busy), 32'd0);
        do_read(4'd7);

        // Reset while waiting for the data byte of a write
        we0 = we_cnt;
        send_byte(8'h8A);
        tick();
        chk("data_busy", 32'(busy), 32'd1);
        rdy  = 1'b0;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check_zero("rst_data");
        tick();
        chk("rst_data_idle", 32'(busy), 32'd0);
        chk("rst_data_no_we", 32'(we_cnt - we0), 32'd0);
        do_read(4'd10);
        do_write(4'd10, 8'hE1);
        do_read(4'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
